conv_enc_framer_2a8: RTL and testbench
======================================

Name: conv_enc_framer_2a8

Overview:
- Transmit-side front end of the Viterbi link: a rate-1/2, constraint-length-4 (8-state) convolutional encoder with frame control.
- Accepts one information bit per cycle and emits one 2-bit codeword per cycle.
- After every FRAME_LEN data bits, appends 3 zero tail bits so the trellis returns to state 0. The downstream decoder therefore always starts and ends each frame in state 0.
- Feeds the channel/error-injection stage and the Viterbi decoder directly.

Parameters:
- FRAME_LEN, 256, information bits per frame (legal range 2..65535).
- G0, 4'b1111, generator polynomial for codeword bit 0 (octal 17). Bit 3 taps the current input.
- G1, 4'b1101, generator polynomial for codeword bit 1 (octal 15). Bit 3 taps the current input.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- encoder_i  input  1  information bit.
- enable_encoder_i  input  1  input valid; the bit is accepted when enable_encoder_i && in_ready_o.
- in_ready_o  output  1  block can accept a data bit this cycle.
- enc_o  output  2  codeword; bit1 = G1 parity, bit0 = G0 parity.
- enc_valid_o  output  1  enc_o carries a valid codeword this cycle.
- frame_start_o  output  1  pulses with the first data codeword of a frame.
- frame_end_o  output  1  pulses with the last tail codeword of a frame.
- word_ct  output  16  count of completed frames; wraps at 65535 -> 0.

Behaviour:
- Reset (rst low, asynchronous):
  - enc_o=0, enc_valid_o=0, frame_start_o=0, frame_end_o=0, word_ct=0, in_ready_o=0.
  - Shift register sr[2:0]=0, bit counter=0, FSM=IDLE.
  - Reset mid-frame discards the partial frame with no tail emitted; word_ct is not incremented.
- FSM states: IDLE, DATA, TAIL.
  - IDLE: in_ready_o=1. On an accepted bit -> DATA, counter=1, and frame_start_o pulses with that codeword.
  - DATA: in_ready_o=1. Each accepted bit increments the counter. When the FRAME_LEN-th bit is accepted -> TAIL with tail counter=0.
  - TAIL: in_ready_o=0. The block internally feeds d=0 for exactly 3 consecutive cycles, with no stall. On the 3rd tail cycle frame_end_o=1, word_ct increments, and the FSM returns to IDLE.
- in_ready_o is registered: it deasserts in the cycle after the FRAME_LEN-th bit is accepted. It reasserts in the cycle after the 3rd tail codeword is launched, so the next frame can start with zero gap.
- Encoding, per accepted bit d (or tail zero):
  - v = {d, sr[2], sr[1], sr[0]}.
  - enc_o[0] = ^(v & G0); enc_o[1] = ^(v & G1).
  - Then sr <= {d, sr[2:1]}.
- Outputs are registered with 1-cycle latency: a bit accepted at edge N appears on enc_o/enc_valid_o after edge N, valid for one cycle.
- Stall: enable_encoder_i low in IDLE or DATA gives enc_valid_o=0 that cycle; enc_o holds its last value, and sr, counter and FSM are frozen.
- enable_encoder_i is ignored during TAIL; those input bits are not consumed.
- After the tail, sr=000 by construction. The block additionally forces sr=0 on entering IDLE.
- No downstream backpressure: the consumer accepts every valid codeword.
- frame_start_o and frame_end_o are single-cycle pulses, only ever asserted together with enc_valid_o=1.
- For FRAME_LEN=1 behaviour is undefined and must not be instantiated.

Test Plan:
- Reset check: hold rst=0 with random inputs -> all outputs 0. Release rst -> in_ready_o=1 on the next edge, and enc_valid_o stays 0 until the first accepted bit.
- Impulse, FRAME_LEN=4, inputs 1,0,0,0 on consecutive cycles:
  - enc_o sequence 11,11,01,11,00,00,00 with enc_valid_o high for 7 consecutive cycles.
  - frame_start_o on cycle 1, frame_end_o on cycle 7.
  - word_ct=1 afterwards; in_ready_o low for exactly the 3 tail cycles.
- Stall, FRAME_LEN=4, inputs 1,0 then enable low for 5 cycles, then 0,0:
  - Same 7 codewords as the impulse case, with a 5-cycle enc_valid_o gap after the 2nd codeword.
  - sr and counter are unchanged across the gap.
- Back-to-back, FRAME_LEN=256, enable held high with 3 frames of random bits:
  - A reference model matches all 777 codewords.
  - word_ct=3; the ready-low gap is exactly 3 cycles between frames.
- Reset mid-frame: assert rst after the 100th bit of a 256-bit frame -> outputs clear immediately (asynchronous). Restart an impulse frame -> outputs match the fresh-start reference with word_ct=1.
- Counter wrap: force word_ct to 65535, complete one frame -> word_ct=0.

Source files
------------

// File: rtl/conv_enc_framer_2a8.sv
// Rate-1/2, K=4 convolutional encoder with framing: FRAME_LEN data bits
// followed by 3 zero tail bits that return the trellis to state 0.
module conv_enc_framer_2a8 #(
  parameter int unsigned FRAME_LEN = 256,
  parameter logic [3:0]  G0        = 4'b1111,
  parameter logic [3:0]  G1        = 4'b1101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        encoder_i,
  input  logic        enable_encoder_i,
  output logic        in_ready_o,
  output logic [1:0]  enc_o,
  output logic        enc_valid_o,
  output logic        frame_start_o,
  output logic        frame_end_o,
  output logic [15:0] word_ct
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(FRAME_LEN - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [2:0]  r_sr;
  logic [2:0]  w_sr_next;
  logic [15:0] r_bit_cnt;
  logic [15:0] w_bit_cnt_next;
  logic [1:0]  r_tail_cnt;
  logic [1:0]  w_tail_cnt_next;
  logic        r_in_ready;
  logic [1:0]  r_enc;
  logic        r_valid;
  logic        r_start;
  logic        r_end;
  logic [15:0] r_word_ct;

  logic        w_fire;
  logic        w_d;
  logic [3:0]  w_v;
  logic [1:0]  w_cw;
  logic        w_emit;
  logic        w_start;
  logic        w_end;

  // Tail cycles encode a forced zero regardless of the input pins.
  always_comb begin
    w_fire = enable_encoder_i && r_in_ready && (r_state != ST_TAIL);
    w_d    = (r_state == ST_TAIL) ? 1'b0 : encoder_i;
    w_v    = {w_d, r_sr};
    w_cw   = {^(w_v & G1), ^(w_v & G0)};
  end

  always_comb begin
    w_state_next    = r_state;
    w_sr_next       = r_sr;
    w_bit_cnt_next  = r_bit_cnt;
    w_tail_cnt_next = r_tail_cnt;
    w_emit          = 1'b0;
    w_start         = 1'b0;
    w_end           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fire) begin
          w_emit         = 1'b1;
          w_start        = 1'b1;
          w_sr_next      = {w_d, r_sr[2:1]};
          w_bit_cnt_next = 16'd1;
          w_state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_fire) begin
          w_emit    = 1'b1;
          w_sr_next = {w_d, r_sr[2:1]};
          if (r_bit_cnt == LAST_CNT) begin
            w_tail_cnt_next = 2'd0;
            w_state_next    = ST_TAIL;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 16'd1;
          end
        end
      end
      ST_TAIL: begin
        w_emit    = 1'b1;
        w_sr_next = {w_d, r_sr[2:1]};
        if (r_tail_cnt == 2'd2) begin
          w_end          = 1'b1;
          w_sr_next      = 3'b000;
          w_bit_cnt_next = 16'd0;
          w_state_next   = ST_IDLE;
        end else begin
          w_tail_cnt_next = r_tail_cnt + 2'd1;
        end
      end
      default: begin
        w_sr_next      = 3'b000;
        w_bit_cnt_next = 16'd0;
        w_state_next   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_sr       <= 3'b000;
      r_bit_cnt  <= 16'd0;
      r_tail_cnt <= 2'd0;
      r_in_ready <= 1'b0;
      r_enc      <= 2'b00;
      r_valid    <= 1'b0;
      r_start    <= 1'b0;
      r_end      <= 1'b0;
      r_word_ct  <= 16'd0;
    end else begin
      r_state    <= w_state_next;
      r_sr       <= w_sr_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_tail_cnt <= w_tail_cnt_next;
      // Ready tracks the next state so a new frame can start with no gap.
      r_in_ready <= (w_state_next != ST_TAIL);
      if (w_emit) begin
        r_enc <= w_cw;
      end
      r_valid <= w_emit;
      r_start <= w_start;
      r_end   <= w_end;
      if (w_end) begin
        r_word_ct <= r_word_ct + 16'd1;
      end
    end
  end

  assign in_ready_o    = r_in_ready;
  assign enc_o         = r_enc;
  assign enc_valid_o   = r_valid;
  assign frame_start_o = r_start;
  assign frame_end_o   = r_end;
  assign word_ct       = r_word_ct;

endmodule

// File: tb/tb_conv_enc_framer_2a8.sv
// Bench for conv_enc_framer_2a8: vector table on a FRAME_LEN=4 instance and
// randomized frames on a FRAME_LEN=256 instance against a convolution model.
module tb_conv_enc_framer_2a8;

  localparam logic [3:0] G0 = 4'b1111;
  localparam logic [3:0] G1 = 4'b1101;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        en4 = 1'b0, d4 = 1'b0;
  logic        rdy4, vld4, st4, fe4;
  logic [1:0]  enc4;
  logic [15:0] wc4;

  logic        en256 = 1'b0, d256 = 1'b0;
  logic        rdy256, vld256, st256, fe256;
  logic [1:0]  enc256;
  logic [15:0] wc256;

  conv_enc_framer_2a8 #(.FRAME_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .encoder_i(d4), .enable_encoder_i(en4),
    .in_ready_o(rdy4), .enc_o(enc4), .enc_valid_o(vld4),
    .frame_start_o(st4), .frame_end_o(fe4), .word_ct(wc4)
  );

  conv_enc_framer_2a8 #(.FRAME_LEN(256)) u_dut256 (
    .clk(clk), .rst(rst), .encoder_i(d256), .enable_encoder_i(en256),
    .in_ready_o(rdy256), .enc_o(enc256), .enc_valid_o(vld256),
    .frame_start_o(st256), .frame_end_o(fe256), .word_ct(wc256)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          en;
    bit          d;
    logic [1:0]  enc;
    bit          vld;
    bit          st;
    bit          fe;
    bit          rdy;
    logic [15:0] wc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit en, bit d, logic [1:0] enc, bit vld, bit st,
                              bit fe, bit rdy, logic [15:0] wc);
    vec_t v;
    v.en = en; v.d = d; v.enc = enc; v.vld = vld;
    v.st = st; v.fe = fe; v.rdy = rdy; v.wc = wc;
    return v;
  endfunction

  bit stim_q[$];

  // Reference: each codeword is the GF(2) convolution of the frame's bit
  // stream (data then 3 zeros, history zero before the frame) with G0/G1.
  task automatic run_frames(input string tag);
    int nbits = stim_q.size();
    int nfr   = nbits / 256;
    int ncyc  = nbits + 3 * nfr + 6;
    logic [3:0] exp_q[$];
    logic [3:0] got_q[$];
    int gaps[$];
    int low_run = 0;
    int idx     = 0;
    int first_v = -1;
    int last_v  = -1;
    for (int fr = 0; fr < nfr; fr++) begin
      for (int n = 0; n < 259; n++) begin
        bit c0, c1, x;
        c0 = 1'b0;
        c1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
          x  = (n - k >= 0 && n - k < 256) ? stim_q[fr * 256 + n - k] : 1'b0;
          c0 = c0 ^ (G0[3-k] & x);
          c1 = c1 ^ (G1[3-k] & x);
        end
        exp_q.push_back({c1, c0, (n == 0), (n == 258)});
      end
    end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (vld256) begin
        got_q.push_back({enc256, st256, fe256});
        if (first_v < 0) first_v = c;
        last_v = c;
      end
      if (!rdy256) low_run++;
      else if (low_run > 0) begin
        gaps.push_back(low_run);
        low_run = 0;
      end
      if (rdy256 && idx < nbits) begin
        en256 = 1'b1;
        d256  = stim_q[idx];
        idx++;
      end else begin
        en256 = (idx < nbits);
        d256  = 1'($urandom);
      end
    end
    en256 = 1'b0;
    chk({tag, " bits_consumed"}, idx, nbits);
    chk({tag, " codeword_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s cw%0d {enc,start,end}", tag, i), got_q[i], exp_q[i]);
    chk({tag, " valid_contiguous"}, last_v - first_v + 1, got_q.size());
    chk({tag, " ready_gap_count"}, gaps.size(), nfr);
    foreach (gaps[i]) chk($sformatf("%s ready_gap%0d", tag, i), gaps[i], 3);
  endtask

  initial begin
    // Impulse on FRAME_LEN=4
    tbl.push_back(mk(1, 1, 2'b11, 1, 1, 0, 1, 16'd0));
    tbl.push_back(mk(1, 0, 2'b11, 1, 0, 0, 1, 16'd0));
    tbl.push_back(mk(1, 0, 2'b01, 1, 0, 0, 1, 16'd0));
    tbl.push_back(mk(1, 0, 2'b11, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 1, 2'b00, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 1, 2'b00, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 2'b00, 1, 0, 1, 1, 16'd1));
    tbl.push_back(mk(0, 1, 2'b00, 0, 0, 0, 1, 16'd1));
    // Same impulse with a 5-cycle stall after the second bit
    tbl.push_back(mk(1, 1, 2'b11, 1, 1, 0, 1, 16'd1));
    tbl.push_back(mk(1, 0, 2'b11, 1, 0, 0, 1, 16'd1));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 1, 2'b11, 0, 0, 0, 1, 16'd1));
    tbl.push_back(mk(1, 0, 2'b01, 1, 0, 0, 1, 16'd1));
    tbl.push_back(mk(1, 0, 2'b11, 1, 0, 0, 0, 16'd1));
    tbl.push_back(mk(1, 1, 2'b00, 1, 0, 0, 0, 16'd1));
    tbl.push_back(mk(1, 1, 2'b00, 1, 0, 0, 0, 16'd1));
    tbl.push_back(mk(1, 1, 2'b00, 1, 0, 1, 1, 16'd2));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0, 1, 16'd2));

    // Reset held with random inputs
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en4 = 1'($urandom); d4 = 1'($urandom);
      en256 = 1'($urandom); d256 = 1'($urandom);
      chk($sformatf("reset_hold%0d dut4", i), {rdy4, enc4, vld4, st4, fe4, wc4}, 0);
      chk($sformatf("reset_hold%0d dut256", i), {rdy256, enc256, vld256, st256, fe256, wc256}, 0);
    end
    en4 = 1'b0; en256 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset dut4 {rdy,vld}", {rdy4, vld4}, 2'b10);
    chk("post_reset dut256 {rdy,vld}", {rdy256, vld256}, 2'b10);
    @(negedge clk);
    chk("idle dut4 vld", vld4, 0);

    foreach (tbl[i]) begin
      en4 = tbl[i].en;
      d4  = tbl[i].d;
      @(negedge clk);
      chk($sformatf("vec%0d {enc,vld,st,fe,rdy,wc}", i),
          {enc4, vld4, st4, fe4, rdy4, wc4},
          {tbl[i].enc, tbl[i].vld, tbl[i].st, tbl[i].fe, tbl[i].rdy, tbl[i].wc});
    end
    en4 = 1'b0;

    // Three back-to-back random frames
    stim_q.delete();
    for (int i = 0; i < 768; i++) stim_q.push_back(1'($urandom));
    run_frames("b2b");
    chk("b2b word_ct", wc256, 3);

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      en256 = 1'b1;
      d256  = 1'($urandom);
    end
    @(negedge clk);
    en256 = 1'b0;
    chk("midframe vld before reset", vld256, 1);
    rst = 1'b0;
    #1;
    chk("midframe async clear", {rdy256, enc256, vld256, st256, fe256, wc256}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    stim_q.delete();
    stim_q.push_back(1'b1);
    for (int i = 1; i < 256; i++) stim_q.push_back(1'b0);
    run_frames("restart");
    chk("restart word_ct", wc256, 1);

    // word_ct wrap on FRAME_LEN=4
    @(negedge clk);
    force u_dut4.r_word_ct = 16'hFFFF;
    #1;
    release u_dut4.r_word_ct;
    chk("wrap preload", wc4, 16'hFFFF);
    begin
      bit saw_end;
      saw_end = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (fe4) saw_end = 1'b1;
        en4 = (i < 4);
        d4  = 1'($urandom);
      end
      en4 = 1'b0;
      chk("wrap frame_end seen", saw_end, 1);
      chk("wrap word_ct", wc4, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
